// File: rtl/ddr3_emif_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_emif_arbiter
//  Purpose  : Two-port burst arbiter onto the DDR3 EMIF Avalon-MM port, with
//             an outstanding-read tag FIFO steering read beats to their owner.
//  Revision : 1.0  initial release
// ============================================================================
module ddr3_emif_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic         ddr3_emif_clk,
  input  logic         ddr3_emif_rst,
  input  logic         m0_read,
  input  logic [21:0]  m0_addr,
  input  logic [4:0]   m0_burst_count,
  output logic         m0_ready,
  output logic [255:0] m0_rddata,
  output logic         m0_rddata_valid,
  input  logic         m1_read,
  input  logic         m1_write,
  input  logic [21:0]  m1_addr,
  input  logic [4:0]   m1_burst_count,
  input  logic [255:0] m1_write_data,
  input  logic [31:0]  m1_byte_enable,
  output logic         m1_ready,
  output logic [255:0] m1_rddata,
  output logic         m1_rddata_valid,
  input  logic         ddr3_emif_ready,
  input  logic [255:0] ddr3_emif_read_data,
  input  logic         ddr3_emif_rddata_valid,
  output logic         ddr3_emif_read,
  output logic         ddr3_emif_write,
  output logic [21:0]  ddr3_emif_addr,
  output logic [4:0]   ddr3_emif_burst_count,
  output logic [255:0] ddr3_emif_write_data,
  output logic [31:0]  ddr3_emif_byte_enable,
  output logic         err_orphan
);

  localparam int c_AW = $clog2(MAX_OUTSTANDING);
  localparam int c_SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G0_RD = 2'd1,
    G1_RD = 2'd2,
    G1_WR = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_emif_read;
  logic            r_emif_write;
  logic [21:0]     r_addr;
  logic [4:0]      r_bc;
  logic [4:0]      r_wr_left;
  logic [c_SW-1:0] r_starve;
  logic [5:0]      r_tag_mem [MAX_OUTSTANDING];
  logic [c_AW:0]   r_wptr;
  logic [c_AW:0]   r_rptr;
  logic [4:0]      r_rd_beat;
  logic            r_err_orphan;

  logic [4:0]      w_m0_bc;
  logic [4:0]      w_m1_bc;
  logic [c_AW:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_p0_elig;
  logic            w_p1_elig;
  logic            w_p1_req;
  logic            w_starved;
  logic            w_pick_p1;
  logic            w_push;
  logic [5:0]      w_head;
  logic            w_beat_ok;
  logic            w_pop;

  // A zero burst count would never terminate a burst, so it is treated as one beat.
  assign w_m0_bc   = (m0_burst_count == 5'd0) ? 5'd1 : m0_burst_count;
  assign w_m1_bc   = (m1_burst_count == 5'd0) ? 5'd1 : m1_burst_count;

  assign w_count   = r_wptr - r_rptr;
  assign w_full    = (w_count == (c_AW + 1)'(MAX_OUTSTANDING));
  assign w_empty   = (r_wptr == r_rptr);

  assign w_p0_elig = m0_read && !w_full;
  assign w_p1_elig = m1_write || (m1_read && !w_full);
  assign w_p1_req  = m1_read || m1_write;
  assign w_starved = (r_starve >= c_SW'(STARVE_LIMIT));
  assign w_pick_p1 = w_p1_elig && (!w_p0_elig || w_starved);

  assign w_push    = ((r_state == G0_RD) || (r_state == G1_RD)) && ddr3_emif_ready;
  assign w_head    = r_tag_mem[r_rptr[c_AW-1:0]];
  assign w_beat_ok = ddr3_emif_rddata_valid && !w_empty;
  assign w_pop     = w_beat_ok && (r_rd_beat == (w_head[4:0] - 5'd1));

  assign ddr3_emif_read        = r_emif_read;
  assign ddr3_emif_write       = r_emif_write;
  assign ddr3_emif_addr        = r_addr;
  assign ddr3_emif_burst_count = r_bc;
  assign ddr3_emif_write_data  = r_emif_write ? m1_write_data  : 256'd0;
  assign ddr3_emif_byte_enable = r_emif_write ? m1_byte_enable : 32'd0;

  assign m0_ready        = (r_state == G0_RD) && ddr3_emif_ready;
  assign m1_ready        = ((r_state == G1_RD) || (r_state == G1_WR)) && ddr3_emif_ready;
  assign m0_rddata       = ddr3_emif_read_data;
  assign m1_rddata       = ddr3_emif_read_data;
  assign m0_rddata_valid = w_beat_ok && !w_head[5];
  assign m1_rddata_valid = w_beat_ok &&  w_head[5];
  assign err_orphan      = r_err_orphan;

  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      r_state      <= IDLE;
      r_emif_read  <= 1'b0;
      r_emif_write <= 1'b0;
      r_addr       <= '0;
      r_bc         <= '0;
      r_wr_left    <= '0;
      r_starve     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_p1) begin
            r_state      <= m1_write ? G1_WR : G1_RD;
            r_emif_read  <= !m1_write;
            r_emif_write <= m1_write;
            r_addr       <= m1_addr;
            r_bc         <= w_m1_bc;
            r_wr_left    <= w_m1_bc;
            r_starve     <= '0;
          end else if (w_p0_elig) begin
            r_state     <= G0_RD;
            r_emif_read <= 1'b1;
            r_addr      <= m0_addr;
            r_bc        <= w_m0_bc;
            // Saturate so a blocked port-1 read cannot wrap the counter.
            if (!w_p1_req)
              r_starve <= '0;
            else if (!w_starved)
              r_starve <= r_starve + c_SW'(1);
          end else if (!w_p1_req) begin
            r_starve <= '0;
          end
        end
        G0_RD, G1_RD: begin
          if (ddr3_emif_ready) begin
            r_state     <= IDLE;
            r_emif_read <= 1'b0;
            r_addr      <= '0;
            r_bc        <= '0;
          end
        end
        G1_WR: begin
          if (ddr3_emif_ready) begin
            r_wr_left <= r_wr_left - 5'd1;
            if (r_wr_left == 5'd1) begin
              r_state      <= IDLE;
              r_emif_write <= 1'b0;
              r_addr       <= '0;
              r_bc         <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ddr3_emif_clk) begin
    if (w_push)
      r_tag_mem[r_wptr[c_AW-1:0]] <= {(r_state == G1_RD), r_bc};
  end

  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_rd_beat    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + (c_AW + 1)'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + (c_AW + 1)'(1);
        r_rd_beat <= '0;
      end else if (w_beat_ok) begin
        r_rd_beat <= r_rd_beat + 5'd1;
      end
      if (ddr3_emif_rddata_valid && w_empty)
        r_err_orphan <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_emif_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr3_emif_arbiter
//  Purpose  : Directed self-checking bench with a transaction-level tag model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_emif_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         m0_read;
  logic [21:0]  m0_addr;
  logic [4:0]   m0_burst_count;
  logic         m0_ready;
  logic [255:0] m0_rddata;
  logic         m0_rddata_valid;
  logic         m1_read;
  logic         m1_write;
  logic [21:0]  m1_addr;
  logic [4:0]   m1_burst_count;
  logic [255:0] m1_write_data;
  logic [31:0]  m1_byte_enable;
  logic         m1_ready;
  logic [255:0] m1_rddata;
  logic         m1_rddata_valid;
  logic         emif_ready = 1'b1;
  logic [255:0] emif_rdata;
  logic         emif_rvalid;
  logic         emif_read;
  logic         emif_write;
  logic [21:0]  emif_addr;
  logic [4:0]   emif_bc;
  logic [255:0] emif_wdata;
  logic [31:0]  emif_be;
  logic         err_orphan;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int owner; int bc; } tag_t;
  tag_t mq[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   m_beat      = 0;
  logic m_orph      = 1'b0;
  int   n_m0        = 0;
  int   n_m1        = 0;
  int   wr_beats    = 0;
  int   last_wr_cyc = 0;
  int   beat_id     = 0;
  logic tog_en      = 1'b0;
  logic rdy_lvl     = 1'b1;

  ddr3_emif_arbiter #(.MAX_OUTSTANDING(8), .STARVE_LIMIT(4)) dut (
    .ddr3_emif_clk          (clk),
    .ddr3_emif_rst          (rst),
    .m0_read                (m0_read),
    .m0_addr                (m0_addr),
    .m0_burst_count         (m0_burst_count),
    .m0_ready               (m0_ready),
    .m0_rddata              (m0_rddata),
    .m0_rddata_valid        (m0_rddata_valid),
    .m1_read                (m1_read),
    .m1_write               (m1_write),
    .m1_addr                (m1_addr),
    .m1_burst_count         (m1_burst_count),
    .m1_write_data          (m1_write_data),
    .m1_byte_enable         (m1_byte_enable),
    .m1_ready               (m1_ready),
    .m1_rddata              (m1_rddata),
    .m1_rddata_valid        (m1_rddata_valid),
    .ddr3_emif_ready        (emif_ready),
    .ddr3_emif_read_data    (emif_rdata),
    .ddr3_emif_rddata_valid (emif_rvalid),
    .ddr3_emif_read         (emif_read),
    .ddr3_emif_write        (emif_write),
    .ddr3_emif_addr         (emif_addr),
    .ddr3_emif_burst_count  (emif_bc),
    .ddr3_emif_write_data   (emif_wdata),
    .ddr3_emif_byte_enable  (emif_be),
    .err_orphan             (err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // EMIF ready: steady level, or toggling every cycle for the write test.
  initial forever begin
    @(posedge clk);
    #1;
    emif_ready = tog_en ? ~emif_ready : rdy_lvl;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] coerce(input logic [4:0] b);
    return (b == 5'd0) ? 5'd1 : b;
  endfunction

  // Model: in-order list of outstanding read bursts and the sticky orphan flag.
  always @(negedge clk) begin : cmp
    logic e0, e1;
    cyc++;
    if (rst) begin
      mq.delete();
      m_beat = 0;
      m_orph = 1'b0;
    end else begin
      e0 = emif_rvalid && (mq.size() > 0) && (mq[0].owner == 0);
      e1 = emif_rvalid && (mq.size() > 0) && (mq[0].owner == 1);
      check("rvalid0", m0_rddata_valid, e0);
      check("rvalid1", m1_rddata_valid, e1);
      if (emif_rvalid) begin
        check("rdata0", m0_rddata, emif_rdata);
        check("rdata1", m1_rddata, emif_rdata);
      end
      check("orphan_flag", err_orphan, m_orph);
      if (m0_rddata_valid) n_m0++;
      if (m1_rddata_valid) n_m1++;
      if (emif_rvalid) begin
        if (mq.size() == 0) m_orph = 1'b1;
        else begin
          m_beat++;
          if (m_beat == mq[0].bc) begin
            mq.delete(0);
            m_beat = 0;
          end
        end
      end
      check("ready_excl", m0_ready & m1_ready, 0);
      if (m0_ready) begin
        check("g0_cmd", {emif_read, emif_write, emif_addr, emif_bc},
              {2'b10, m0_addr, coerce(m0_burst_count)});
        mq.push_back('{0, int'(coerce(m0_burst_count))});
        grant_log.push_back(0);
        grant_cyc.push_back(cyc);
      end
      if (m1_ready && !emif_write) begin
        check("g1_cmd", {emif_read, emif_write, emif_addr, emif_bc},
              {2'b10, m1_addr, coerce(m1_burst_count)});
        mq.push_back('{1, int'(coerce(m1_burst_count))});
        grant_log.push_back(1);
        grant_cyc.push_back(cyc);
      end
      if (emif_write) begin
        check("wr_hold", {emif_read, emif_addr, emif_bc}, {1'b0, m1_addr, coerce(m1_burst_count)});
        check("wr_data", emif_wdata, m1_write_data);
        check("wr_be", emif_be, m1_byte_enable);
        check("wr_ready", m1_ready, emif_ready);
        if (emif_ready) begin
          wr_beats++;
          last_wr_cyc = cyc;
        end
      end
    end
  end

  task automatic rd_cmd(input int port, input logic [21:0] a, input logic [4:0] bc, output int lat);
    @(posedge clk);
    #1;
    if (port == 0) begin m0_read = 1'b1; m0_addr = a; m0_burst_count = bc; end
    else begin m1_read = 1'b1; m1_addr = a; m1_burst_count = bc; end
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if ((port == 0) ? m0_ready : m1_ready) break;
      lat++;
    end
    check("cmd_accepted", lat < 200, 1);
    @(posedge clk);
    #1;
    if (port == 0) m0_read = 1'b0; else m1_read = 1'b0;
  endtask

  task automatic m1_wr(input logic [21:0] a, input logic [4:0] bc);
    int beats = 0;
    int guard = 0;
    @(posedge clk);
    #1;
    m1_write = 1'b1; m1_addr = a; m1_burst_count = bc;
    m1_write_data = {8{32'hA500_0000 + beats}};
    m1_byte_enable = 32'hFFFF_0000 ^ beats;
    while (beats < int'(bc) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (m1_ready) begin
        beats++;
        @(posedge clk);
        #1;
        m1_write_data = {8{32'hA500_0000 + beats}};
        m1_byte_enable = 32'hFFFF_0000 ^ beats;
      end
    end
    m1_write = 1'b0;
    check("wr_done", beats, bc);
  endtask

  task automatic ret(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      emif_rvalid = 1'b1;
      emif_rdata  = {8{32'hD000_0000 + beat_id}};
      beat_id++;
    end
    @(posedge clk);
    #1;
    emif_rvalid = 1'b0;
  endtask

  initial begin
    int lat, lat9, b0, b1, wb, gb;
    int exp_order[6];
    int bcs[8];
    exp_order = '{0, 0, 0, 0, 1, 0};
    bcs       = '{2, 0, 3, 1, 1, 2, 1, 4};
    rst = 1'b1;
    m0_read = 1'b0; m0_addr = '0; m0_burst_count = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_burst_count = '0;
    m1_write_data = '0; m1_byte_enable = '0;
    emif_rvalid = 1'b0; emif_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle outputs
    repeat (10) begin
      @(negedge clk);
      check("idle_cmd", {emif_read, emif_write, emif_addr, emif_bc}, 0);
      check("idle_wdata", emif_wdata, 0);
      check("idle_be", emif_be, 0);
      check("idle_ready", {m0_ready, m1_ready, m0_rddata_valid, m1_rddata_valid}, 0);
      check("idle_orphan", err_orphan, 0);
    end

    // Single port-0 read, burst 4
    b0 = n_m0; b1 = n_m1;
    rd_cmd(0, 22'h100, 5'd4, lat);
    check("g0_latency", lat, 1);
    ret(4);
    @(negedge clk);
    check("t2_m0_beats", n_m0 - b0, 4);
    check("t2_m1_beats", n_m1 - b1, 0);
    check("t2_fifo_empty", mq.size(), 0);

    // Starvation guard: port 0 continuous, port 1 read held
    repeat (3) @(posedge clk);
    gb = grant_log.size();
    @(posedge clk);
    #1;
    m0_read = 1'b1; m0_addr = 22'h040; m0_burst_count = 5'd1;
    m1_read = 1'b1; m1_addr = 22'h300000; m1_burst_count = 5'd1;
    fork
      begin : p1
        int g = 0;
        while (g < 100) begin
          @(negedge clk);
          g++;
          if (m1_ready) break;
        end
        check("starve_served", g < 100, 1);
        @(posedge clk);
        #1 m1_read = 1'b0;
      end
      begin : p0
        int n = 0;
        int g = 0;
        while (n < 5 && g < 100) begin
          @(negedge clk);
          g++;
          if (m0_ready) n++;
        end
        @(posedge clk);
        #1 m0_read = 1'b0;
      end
    join
    for (int i = 0; i < 6; i++)
      check("starve_order", (gb + i < grant_log.size()) ? grant_log[gb + i] : 9, exp_order[i]);
    check("starve_count", grant_log.size() - gb, 6);
    ret(6);
    @(negedge clk);
    check("t3_fifo_empty", mq.size(), 0);

    // Write burst of 8 with toggling ready; port-0 read arrives mid-burst
    repeat (3) @(posedge clk);
    wb = wr_beats; gb = grant_log.size();
    tog_en = 1'b1;
    fork
      m1_wr(22'h2A0, 5'd8);
      begin
        repeat (3) @(posedge clk);
        rd_cmd(0, 22'h155, 5'd2, lat);
      end
    join
    tog_en = 1'b0;
    check("wr_beats", wr_beats - wb, 8);
    check("m0_blocked", (grant_log.size() > gb) && (grant_cyc[grant_cyc.size() - 1] > last_wr_cyc), 1);
    ret(2);
    @(negedge clk);
    check("t4_fifo_empty", mq.size(), 0);

    // Fill the tag FIFO with 8 reads, then a 9th must wait for a pop
    repeat (3) @(posedge clk);
    gb = grant_log.size(); b0 = n_m0; b1 = n_m1;
    for (int i = 0; i < 8; i++)
      rd_cmd(i % 2, 22'h1000 + 22'(i * 16), 5'(bcs[i]), lat);
    fork
      rd_cmd(0, 22'h2000, 5'd1, lat9);
      begin
        repeat (10) @(negedge clk);
        check("ninth_blocked", grant_log.size() - gb, 8);
        ret(bcs[0]);
      end
    join
    check("ninth_waited", (lat9 > 10) && (lat9 < 200), 1);
    ret(14);
    @(negedge clk);
    check("t5_m0_beats", n_m0 - b0, 8);
    check("t5_m1_beats", n_m1 - b1, 8);
    check("t5_fifo_empty", mq.size(), 0);

    // Orphan beat with nothing outstanding
    repeat (3) @(posedge clk);
    b0 = n_m0; b1 = n_m1;
    @(posedge clk);
    #1 emif_rvalid = 1'b1; emif_rdata = {8{32'hBAD0_0001}};
    @(posedge clk);
    #1 emif_rvalid = 1'b0;
    @(negedge clk);
    check("orphan_set", err_orphan, 1);
    repeat (5) @(negedge clk);
    check("orphan_sticky", err_orphan, 1);
    check("orphan_no_valid", (n_m0 - b0) + (n_m1 - b1), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("orphan_reset", err_orphan, 0);

    // Reset with a read outstanding discards its tag
    rd_cmd(0, 22'h077, 5'd4, lat);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    b0 = n_m0;
    ret(1);
    @(negedge clk);
    check("reset_discards_tags", err_orphan, 1);
    check("reset_no_valid", n_m0 - b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
